alu: RTL and testbench

16-bit, 11-operation ALU for the datapath: add, subtract, signed multiply, unsigned divide/remainder, bitwise logic and single-bit shifts on two 16-bit operands. A 4-bit `select` code chooses the operation and the result appears on one registered 16-bit output. Add and subtract use a ripple-carry adder. Multiply and divide are multi-cycle iterative units that restart automatically whenever the operands or the opcode change.

---
 rtl/alu_pkg.sv | 63 ++++++
 rtl/alu_rca16.sv | 24 ++
 rtl/alu.sv | 163 ++++++++++++++++
 tb/tb_alu.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants, FSM state type and datapath helpers for the 16-bit ALU.
package alu_pkg;

  localparam int unsigned W = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ASR = 4'd10;

  // Both iterative units retire 2 bits per cycle, so 8 steps cover 16 bits.
  localparam logic [3:0] CNT_END = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Radix-4 Booth partial product for window {b[2i+1], b[2i], b[2i-1]}.
  // Only the low W bits of the product are kept, so mod-2^W arithmetic suffices.
  function automatic logic [W-1:0] booth_pp(input logic [2:0] win, input logic [W-1:0] m);
    logic [W-1:0] pp;
    pp = '0;
    case (win)
      3'b001, 3'b010: pp = m;
      3'b011:         pp = m << 1;
      3'b100:         pp = -(m << 1);
      3'b101, 3'b110: pp = -m;
      default:        pp = '0;
    endcase
    return pp;
  endfunction

  // One restoring-division step: returns {remainder, quotient}.
  // With a zero divisor every trial subtraction succeeds, which naturally
  // yields quotient all-ones and remainder equal to the dividend.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r,
                                               input logic [W-1:0] q,
                                               input logic [W-1:0] d);
    logic [W:0]   t;
    logic [W-1:0] qn;
    t  = {r, q[W-1]};
    qn = {q[W-2:0], 1'b0};
    if (t >= {1'b0, d}) begin
      t     = t - {1'b0, d};
      qn[0] = 1'b1;
    end
    return {t[W-1:0], qn};
  endfunction

endpackage

// File: rtl/alu_rca16.sv
// 16-bit ripple-carry adder used for both ADD and SUB.
module rca16
  import alu_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Carry ripples LSB to MSB through a block-local variable.
  always_comb begin : ripple
    logic c;
    c    = cin;
    sum  = '0;
    for (int unsigned i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/alu.sv
// 16-bit ALU: single-cycle add/sub/logic/shift plus iterative Booth multiply
// and restoring divide that restart whenever operands or opcode change.
module alu
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   select,
  output logic [W-1:0] result
);

  logic [W-1:0] a_q, b_q;
  logic [3:0]   sel_q;
  logic         chg, multi, load, wb, done;
  state_t       state_q, state_d;

  logic [W-1:0] add_sum, sub_sum;
  logic         add_cout_unused, sub_cout_unused;

  logic [W-1:0] mc, mq, prod;
  logic         q1;
  logic [3:0]   mul_cnt;

  logic [W-1:0]   rem, quo, dvs;
  logic [3:0]     div_cnt;
  logic [2*W-1:0] s1, s2;

  logic [W-1:0] res_d;

  rca16 u_add (.a(A), .b(B),  .cin(1'b0), .sum(add_sum), .cout(add_cout_unused));
  rca16 u_sub (.a(A), .b(~B), .cin(1'b1), .sum(sub_sum), .cout(sub_cout_unused));

  // Live inputs are compared against last cycle's capture so the load of a
  // new operation coincides with the capture edge (keeps latency at 10).
  always_comb begin
    chg   = (A != a_q) || (B != b_q) || (select != sel_q);
    multi = is_multi(select);
    done  = (sel_q == OP_MUL) ? (mul_cnt == CNT_END) : (div_cnt == CNT_END);
  end

  // Input capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sel_q <= '0;
    end else begin
      a_q   <= A;
      b_q   <= B;
      sel_q <= select;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state, unit load and result writeback strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    wb      = 1'b0;
    if (chg) begin
      state_d = multi ? S_RUN : S_IDLE;
      load    = multi;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (multi) begin
            state_d = S_RUN;
            load    = 1'b1;
          end
        end
        S_RUN: begin
          if (done) begin
            state_d = S_DONE;
            wb      = 1'b1;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Radix-4 Booth multiplier: multiplicand shifts left by 2, multiplier right by 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mc      <= '0;
      mq      <= '0;
      q1      <= 1'b0;
      prod    <= '0;
      mul_cnt <= '0;
    end else if (load) begin
      mc      <= A;
      mq      <= B;
      q1      <= 1'b0;
      prod    <= '0;
      mul_cnt <= '0;
    end else if (state_q == S_RUN && mul_cnt != CNT_END) begin
      prod    <= prod + booth_pp({mq[1:0], q1}, mc);
      mc      <= mc << 2;
      mq      <= {2'b00, mq[W-1:2]};
      q1      <= mq[1];
      mul_cnt <= mul_cnt + 4'd1;
    end
  end

  // Two chained restoring steps per cycle.
  always_comb begin
    s1 = div_step(rem, quo, dvs);
    s2 = div_step(s1[2*W-1:W], s1[W-1:0], dvs);
  end

  // Restoring divider state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      div_cnt <= '0;
    end else if (load) begin
      rem     <= '0;
      quo     <= A;
      dvs     <= B;
      div_cnt <= '0;
    end else if (state_q == S_RUN && div_cnt != CNT_END) begin
      rem     <= s2[2*W-1:W];
      quo     <= s2[W-1:0];
      div_cnt <= div_cnt + 4'd1;
    end
  end

  // Result selection.
  always_comb begin
    res_d = '0;
    case (select)
      OP_ADD:  res_d = add_sum;
      OP_SUB:  res_d = sub_sum;
      OP_MUL:  res_d = prod;
      OP_DIV:  res_d = quo;
      OP_MOD:  res_d = rem;
      OP_AND:  res_d = A & B;
      OP_OR:   res_d = A | B;
      OP_XOR:  res_d = A ^ B;
      OP_SHL:  res_d = {A[W-2:0], 1'b0};
      OP_SHR:  res_d = {1'b0, A[W-1:1]};
      OP_ASR:  res_d = {A[W-1], A[W-1:1]};
      default: res_d = '0;
    endcase
  end

  // Result register: single-cycle ops update every edge, iterative ops only on writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                result <= '0;
    else if (!multi || wb)   result <= res_d;
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the 16-bit ALU.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A, B;
  logic [3:0]  select;
  logic [15:0] result;

  int vectors     = 0;
  int miscompares = 0;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .select (select),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s);
    @(negedge clk);
    A = a;
    B = b;
    select = s;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    A = 16'd0;
    B = 16'd0;
    select = 4'd0;
    #1;
    vectors++;
    if (result !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_async: result=0x%h expected 0x0000", result);
    end
    cycles(2);
    vectors++;
    if (result !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_held: result=0x%h expected 0x0000", result);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_sweep(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp [11]);
    for (int s = 0; s < 11; s++) begin
      drive(a, b, s[3:0]);
      cycles(15);
      vectors++;
      if (result !== exp[s]) begin
        miscompares++;
        $display("FAIL sweep A=%0d B=%0d sel=%0d: result=%0d expected %0d", a, b, s, result, exp[s]);
      end
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic [15:0] exp;
  } vec_t;

  task automatic test_edges;
    vec_t v [11];
    v[0]  = '{16'hFFFD, 16'd5,    4'd2,  16'hFFF1};
    v[1]  = '{16'hFFFE, 16'hFFFD, 4'd2,  16'h0006};
    v[2]  = '{16'h8000, 16'd2,    4'd2,  16'h0000};
    v[3]  = '{16'h0000, 16'd1,    4'd1,  16'hFFFF};
    v[4]  = '{16'h8000, 16'd0,    4'd10, 16'hC000};
    v[5]  = '{16'h8000, 16'd0,    4'd9,  16'h4000};
    v[6]  = '{16'hFFFF, 16'd1,    4'd0,  16'h0000};
    v[7]  = '{16'h8001, 16'd0,    4'd8,  16'h0002};
    v[8]  = '{16'hFFFF, 16'hFFFF, 4'd12, 16'h0000};
    v[9]  = '{16'd1234, 16'd0,    4'd3,  16'hFFFF};
    v[10] = '{16'd1234, 16'd0,    4'd4,  16'd1234};
    for (int i = 0; i < 11; i++) begin
      drive(v[i].a, v[i].b, v[i].s);
      cycles(12);
      vectors++;
      if (result !== v[i].exp) begin
        miscompares++;
        $display("FAIL edge[%0d] A=0x%h B=0x%h sel=%0d: result=0x%h expected 0x%h",
                 i, v[i].a, v[i].b, v[i].s, result, v[i].exp);
      end
    end
    // Nonzero source before select=15 so the zero result is observable.
    drive(16'd7, 16'd9, 4'd0);
    cycles(1);
    drive(16'd7, 16'd9, 4'd15);
    cycles(1);
    vectors++;
    if (result !== 16'd0) begin
      miscompares++;
      $display("FAIL sel15_zero: result=0x%h expected 0x0000", result);
    end
  endtask

  task automatic test_latency;
    drive(16'd5, 16'd6, 4'd0);
    cycles(1);
    vectors++;
    if (result !== 16'd11) begin
      miscompares++;
      $display("FAIL comb_latency: result=%0d expected 11", result);
    end
    drive(16'd194, 16'd69, 4'd2);
    cycles(9);
    vectors++;
    if (result !== 16'd11) begin
      miscompares++;
      $display("FAIL mul_hold_9: result=%0d expected 11", result);
    end
    cycles(1);
    vectors++;
    if (result !== 16'd13386) begin
      miscompares++;
      $display("FAIL mul_latency_10: result=%0d expected 13386", result);
    end
  endtask

  task automatic test_mid_reset;
    drive(16'd447, 16'd38, 4'd2);
    cycles(3);
    vectors++;
    if (result !== 16'd13386) begin
      miscompares++;
      $display("FAIL mul_no_intermediate: result=%0d expected 13386", result);
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (result !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_reset_async: result=%0d expected 0", result);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cycles(10);
    vectors++;
    if (result !== 16'd16986) begin
      miscompares++;
      $display("FAIL mul_after_reset: result=%0d expected 16986", result);
    end
  endtask

  task automatic test_restart_div;
    drive(16'd1000, 16'd7, 4'd3);
    cycles(4);
    drive(16'd1000, 16'd10, 4'd3);
    cycles(9);
    vectors++;
    if (result !== 16'd16986) begin
      miscompares++;
      $display("FAIL div_restart_hold: result=%0d expected 16986", result);
    end
    cycles(1);
    vectors++;
    if (result !== 16'd100) begin
      miscompares++;
      $display("FAIL div_restart_value: result=%0d expected 100", result);
    end
  endtask

  task automatic test_back_to_back;
    drive(16'd1000, 16'd10, 4'd4);
    cycles(10);
    vectors++;
    if (result !== 16'd0) begin
      miscompares++;
      $display("FAIL mod_after_div: result=%0d expected 0", result);
    end
    drive(16'd1000, 16'd7, 4'd4);
    cycles(10);
    vectors++;
    if (result !== 16'd6) begin
      miscompares++;
      $display("FAIL mod_b7: result=%0d expected 6", result);
    end
    for (int i = 0; i < 20; i++) drive(16'(100 + i), 16'd3, 4'd3);
    cycles(9);
    vectors++;
    if (result !== 16'd6) begin
      miscompares++;
      $display("FAIL churn_hold: result=%0d expected 6", result);
    end
    cycles(1);
    vectors++;
    if (result !== 16'd39) begin
      miscompares++;
      $display("FAIL churn_settle: result=%0d expected 39", result);
    end
  endtask

  initial begin
    logic [15:0] e1 [11];
    logic [15:0] e2 [11];
    logic [15:0] e3 [11];
    e1 = '{16'd485, 16'd409, 16'd16986, 16'd11, 16'd29, 16'd38, 16'd447, 16'd409, 16'd894, 16'd223, 16'd223};
    e2 = '{16'd263, 16'd125, 16'd13386, 16'd2,  16'd56, 16'd64, 16'd199, 16'd135, 16'd388, 16'd97,  16'd97};
    e3 = '{16'd301, 16'd235, 16'd8844,  16'd8,  16'd4,  16'd0,  16'd301, 16'd301, 16'd536, 16'd134, 16'd134};
    test_reset;
    test_sweep(16'd447, 16'd38, e1);
    test_sweep(16'd194, 16'd69, e2);
    test_sweep(16'd268, 16'd33, e3);
    test_edges;
    test_latency;
    test_mid_reset;
    test_restart_div;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
